// File: rtl/regfile_fwd_pkg.sv
// Shared constants and types for the forwarding register file.
// Widths, reset/enable polarities and the forwarding triple live here.
package regfile_fwd_pkg;

  localparam int REG_BUS_W    = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;

  typedef logic [REG_BUS_W-1:0]  reg_word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_word_t ZERO_WORD    = '0;
  localparam logic      RST_ENABLE   = 1'b1;
  localparam logic      WRITE_ENABLE = 1'b1;
  localparam logic      READ_ENABLE  = 1'b1;
  localparam reg_addr_t NOP_REG_ADDR = 5'b00000;

  // One in-flight result: destination, write flag and value.
  typedef struct packed {
    logic      wreg;
    reg_addr_t wd;
    reg_word_t wdata;
  } fwd_t;

  function automatic logic fwd_hit(input fwd_t f, input reg_addr_t addr);
    return (f.wreg == WRITE_ENABLE) && (f.wd == addr);
  endfunction

endpackage

// File: rtl/regfile_fwd_rdport.sv
// One combinational read port: reset/enable/$0 gating, then the youngest
// matching in-flight result (execute, memory, writeback), then the array.
module regfile_fwd_rdport
  import regfile_fwd_pkg::*;
(
  input  logic      rst,
  input  logic      re,
  input  reg_addr_t raddr,
  input  fwd_t      ex_fwd,
  input  fwd_t      mem_fwd,
  input  fwd_t      wb_fwd,
  input  reg_word_t arr_word,
  output reg_word_t rdata
);

  always_comb begin
    rdata = ZERO_WORD;
    if (rst == RST_ENABLE || re != READ_ENABLE) begin
      rdata = ZERO_WORD;
    end else if (raddr == NOP_REG_ADDR) begin
      // $0 stays zero even when a forwarding source names it.
      rdata = ZERO_WORD;
    end else if (fwd_hit(ex_fwd, raddr)) begin
      rdata = ex_fwd.wdata;
    end else if (fwd_hit(mem_fwd, raddr)) begin
      rdata = mem_fwd.wdata;
    end else if (fwd_hit(wb_fwd, raddr)) begin
      rdata = wb_fwd.wdata;
    end else begin
      rdata = arr_word;
    end
  end

endmodule

// File: rtl/regfile_fwd.sv
// 32x32 register file with $0 hardwired to zero, synchronous reset, and two
// combinational read ports that forward from execute, memory and writeback.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int REG_NUM = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_word_t wdata,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output reg_word_t rdata1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_word_t rdata2,
  input  logic      ex_wreg,
  input  reg_addr_t ex_wd,
  input  reg_word_t ex_wdata,
  input  logic      mem_wreg,
  input  reg_addr_t mem_wd,
  input  reg_word_t mem_wdata
);

  reg_word_t regs [REG_NUM];

  fwd_t ex_fwd;
  fwd_t mem_fwd;
  fwd_t wb_fwd;

  assign ex_fwd  = '{wreg: ex_wreg,  wd: ex_wd,  wdata: ex_wdata};
  assign mem_fwd = '{wreg: mem_wreg, wd: mem_wd, wdata: mem_wdata};
  assign wb_fwd  = '{wreg: we,       wd: waddr,  wdata: wdata};

  // Reset wins over a same-cycle write; writes to $0 are dropped.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= ZERO_WORD;
      end
    end else if (we == WRITE_ENABLE && waddr != NOP_REG_ADDR) begin
      regs[waddr] <= wdata;
    end
  end

  regfile_fwd_rdport u_rdport1 (
    .rst      (rst),
    .re       (re1),
    .raddr    (raddr1),
    .ex_fwd   (ex_fwd),
    .mem_fwd  (mem_fwd),
    .wb_fwd   (wb_fwd),
    .arr_word (regs[raddr1]),
    .rdata    (rdata1)
  );

  regfile_fwd_rdport u_rdport2 (
    .rst      (rst),
    .re       (re2),
    .raddr    (raddr2),
    .ex_fwd   (ex_fwd),
    .mem_fwd  (mem_fwd),
    .wb_fwd   (wb_fwd),
    .arr_word (regs[raddr2]),
    .rdata    (rdata2)
  );

endmodule

// File: tb/tb_regfile_fwd.sv
// Bench for regfile_fwd: directed scenarios followed by randomized traffic
// checked against a behavioural register-file model.
module tb_regfile_fwd;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        ex_wreg;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata;
  logic        mem_wreg;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata;

  int n_tests;
  int n_fail;

  logic [31:0] model [32];

  regfile_fwd #(.REG_NUM(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .ex_wreg   (ex_wreg),
    .ex_wd     (ex_wd),
    .ex_wdata  (ex_wdata),
    .mem_wreg  (mem_wreg),
    .mem_wd    (mem_wd),
    .mem_wdata (mem_wdata)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; the model commits what the DUT saw at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      model[waddr] = wdata;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b1; raddr1 = '0;
    re2 = 1'b1; raddr2 = '0;
    ex_wreg = 1'b0; ex_wd = '0; ex_wdata = '0;
    mem_wreg = 1'b0; mem_wd = '0; mem_wdata = '0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  // Reference read: the register's architectural value as decode should see it.
  function automatic logic [31:0] ref_read(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'h0;
    if (ex_wreg && ex_wd == a)   return ex_wdata;
    if (mem_wreg && mem_wd == a) return mem_wdata;
    if (we && waddr == a)        return wdata;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    idle_inputs();
    rst = 1'b1;
    raddr1 = 5'd4;
    #1;
    check("rst_out1", rdata1, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    raddr1 = 5'd4; raddr2 = 5'd31;
    #1;
    check("post_rst_r4", rdata1, 32'h0);
    check("post_rst_r31", rdata2, 32'h0);

    // Reset clear
    write_reg(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5;
    #1;
    check("r5_written", rdata1, 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("reset_clear", rdata1, 32'h0);

    // Basic write/read
    write_reg(5'd3, 32'h12345678);
    raddr2 = 5'd3;
    #1;
    check("basic_rd", rdata2, 32'h12345678);

    // $0 protection
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    ex_wreg = 1'b1; ex_wd = 5'd0; ex_wdata = 32'hAAAA0000;
    raddr1 = 5'd0;
    #1;
    check("r0_same", rdata1, 32'h0);
    tick();
    we = 1'b0; ex_wreg = 1'b0;
    #1;
    check("r0_next", rdata1, 32'h0);

    // Forwarding priority
    write_reg(5'd7, 32'h1);
    raddr1 = 5'd7;
    ex_wreg = 1'b1; ex_wd = 5'd7; ex_wdata = 32'h3;
    mem_wreg = 1'b1; mem_wd = 5'd7; mem_wdata = 32'h2;
    we = 1'b1; waddr = 5'd7; wdata = 32'h4;
    #1;
    check("fwd_ex", rdata1, 32'h3);
    ex_wreg = 1'b0;
    #1;
    check("fwd_mem", rdata1, 32'h2);
    mem_wreg = 1'b0;
    #1;
    check("fwd_wb", rdata1, 32'h4);
    we = 1'b0;
    #1;
    check("fwd_arr", rdata1, 32'h1);

    // Read enable and simultaneous reset
    write_reg(5'd9, 32'h00000099);
    re1 = 1'b0; raddr1 = 5'd9; raddr2 = 5'd9;
    #1;
    check("re1_off", rdata1, 32'h0);
    check("re2_on", rdata2, 32'h00000099);
    re1 = 1'b1;
    rst = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h55555555;
    #1;
    check("rst_hold2", rdata2, 32'h0);
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    check("rst_wins1", rdata1, 32'h0);
    check("rst_wins2", rdata2, 32'h0);

    // Randomized traffic on a narrow address range to provoke forwarding hits
    for (int n = 0; n < 300; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      we        = $urandom_range(0, 1);
      waddr     = 5'($urandom_range(0, 7));
      wdata     = $urandom;
      re1       = ($urandom_range(0, 7) != 0);
      raddr1    = 5'($urandom_range(0, 7));
      re2       = ($urandom_range(0, 7) != 0);
      raddr2    = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 7));
      ex_wreg   = ($urandom_range(0, 3) == 0);
      ex_wd     = 5'($urandom_range(0, 7));
      ex_wdata  = $urandom;
      mem_wreg  = ($urandom_range(0, 3) == 0);
      mem_wd    = 5'($urandom_range(0, 7));
      mem_wdata = $urandom;
      #1;
      check("rnd_p1", rdata1, ref_read(re1, raddr1));
      check("rnd_p2", rdata2, ref_read(re2, raddr2));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_fwd.md
# regfile_fwd

General-purpose register file for the five-stage pipeline: the write-side consumer of the execute-stage result triple (destination address, write flag, write data) once it reaches writeback. It also serves the decode stage's two operand reads. Decode is given a forwarded value when a matching result is still in flight in execute or memory. 32 entries × 32 bits, with `$0` hardwired to zero.

## Interface
Parameters:
- `REG_NUM`, default 32: number of architectural registers. Must be a power of two and equal to 2^width(`RegAddrBus`).

Ports:
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset (`RstEnable` = 1'b1), sampled on the rising edge of `clk`.
- `we`, input, 1: writeback write enable (`WriteEnable`).
- `waddr`, input, `RegAddrBus`: writeback destination register.
- `wdata`, input, `RegBus`: writeback data.
- `re1`, input, 1: read port 1 enable (`ReadEnable`).
- `raddr1`, input, `RegAddrBus`: read port 1 address.
- `rdata1`, output, `RegBus`: read port 1 data.
- `re2`, input, 1: read port 2 enable.
- `raddr2`, input, `RegAddrBus`: read port 2 address.
- `rdata2`, output, `RegBus`: read port 2 data.
- `ex_wreg`, input, 1: execute-stage write flag.
- `ex_wd`, input, `RegAddrBus`: execute-stage destination register.
- `ex_wdata`, input, `RegBus`: execute-stage result.
- `mem_wreg`, input, 1: memory-stage write flag.
- `mem_wd`, input, `RegAddrBus`: memory-stage destination register.
- `mem_wdata`, input, `RegBus`: memory-stage result.

## Operation
- Storage: array `regs[0..REG_NUM-1]` of `RegBus`.
- Write: on the rising edge of `clk`, if `rst` is low, `we` = 1 and `waddr` ≠ 0, then `regs[waddr]` ← `wdata`. Writes to `$0` are discarded.
- Reset: on the rising edge of `clk` with `rst` high, every entry is cleared to `ZeroWord`. Reset takes priority over any write in the same cycle.
- Reads are combinational, one per port, and the two ports are identical and independent. Priority, highest first:
  1. `rst` high → `ZeroWord`.
  2. `re` low → `ZeroWord`.
  3. `raddr` = 0 → `ZeroWord`. This holds even if a forwarding source targets `$0`.
  4. `ex_wreg` = 1 and `ex_wd` = `raddr` → `ex_wdata`.
  5. `mem_wreg` = 1 and `mem_wd` = `raddr` → `mem_wdata`.
  6. `we` = 1 and `waddr` = `raddr` → `wdata` (write-through bypass).
  7. Otherwise → `regs[raddr]`.
- Youngest data wins: execute beats memory, and memory beats writeback.
- Both ports may read the same address in the same cycle and receive identical data.

## Timing
- Read latency is zero: `rdata1` and `rdata2` are purely combinational from their inputs and the array.
- Write latency is one cycle. A write is visible in the array from the edge after it is presented. It is visible on the read ports in the same cycle through the bypass.
- Outputs are `ZeroWord` for as long as `rst` is high.
- After reset deasserts, every register reads `ZeroWord` until written.
- Reset asserted in the same cycle as a write: the write is lost and the entry is zero.
- There is no handshake. Stall and flush are handled upstream by zeroing `wreg` in the pipeline registers, so a bubble never writes and never forwards.

## Structure
- Shared `defines.v` holds the following constants:
  - `RegBus` and `RegAddrBus`.
  - `RegNum` (32) and `RegNumLog2` (5).
  - `ZeroWord`.
  - `RstEnable`, `WriteEnable`, `ReadEnable`.
  - `NOPRegAddr` (5'b00000).
- Sub-module `regfile_rdport`: the combinational priority mux for one read port, covering rules 1–7. It takes `rst`, `re`, `raddr`, the three forwarding triples and the array word. It is instantiated twice, once per port.
- Top level: the array, the write/reset `always` block, and the two port instances.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to `$5`, then assert `rst` for one cycle, then read `$5`.
  - Required: `rdata1` = 0x00000000.
- Basic write/read:
  - Stimulus: `we`=1, `waddr`=3, `wdata`=0x12345678. On the next cycle, read port 2 reads `$3` with `we`=0.
  - Required: `rdata2` = 0x12345678.
- `$0` protection:
  - Stimulus: write 0xFFFFFFFF to `$0`. Also drive `ex_wreg`=1, `ex_wd`=0, `ex_wdata`=0xAAAA0000.
  - Required: reading `$0` returns 0x00000000 in both the same cycle and the next cycle.
- Forwarding priority:
  - Stimulus: `$7` holds 0x1. Set `ex_wd`=`mem_wd`=`waddr`=7 with `ex_wdata`=0x3, `mem_wdata`=0x2, `wdata`=0x4, all flags 1.
  - Required: `rdata1` = 0x3.
  - Then drop `ex_wreg` → 0x2; drop `mem_wreg` → 0x4; drop `we` → 0x1.
- Read enable and simultaneous reset:
  - Stimulus: `re1`=0 while reading a nonzero `$9`.
  - Required: `rdata1` = 0x00000000 while `rdata2` still returns the `$9` contents.
  - Stimulus: assert `rst` together with `we`=1, `waddr`=9.
  - Required: `$9` reads 0x00000000 after reset releases.
